// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the two-port ALU sharing arbiter: widths, ALU opcodes
// and FSM state encoding.
package alu_share_arbiter_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int OPW_DEF   = 3;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SLL = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SRL = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_AND = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant; last_grant only moves when the caller commits
// a grant through upd, so a granted but unaccepted request keeps priority.
module rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic upd,
   output logic gnt,
   output logic gnt_any
);

   logic last_grant;

   always_comb begin
      gnt = 1'b0;
      if (req0 && req1)
         gnt = ~last_grant;
      else if (req1)
         gnt = 1'b1;
   end

   assign gnt_any = req0 | req1;

   always_ff @(posedge clk) begin
      if (rst)
         last_grant <= 1'b1;
      else if (upd)
         last_grant <= gnt;
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters,
// one operation in flight, with a held response slot per requester.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int OPW   = OPW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OPW-1:0]   req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OPW-1:0]   req1_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_result,
   output logic             rsp0_zero,
   output logic             rsp0_sign,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_result,
   output logic             rsp1_zero,
   output logic             rsp1_sign,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero,
   input  logic             alu_sign
);

   logic [1:0]       state;
   logic             owner;
   logic             gnt;
   logic             gnt_any;
   logic             idle;
   logic             hs;
   logic [WIDTH-1:0] a_p0;
   logic [WIDTH-1:0] b_p0;
   logic [OPW-1:0]   op_p0;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req0    (req0_valid),
      .req1    (req1_valid),
      .upd     (hs),
      .gnt     (gnt),
      .gnt_any (gnt_any)
   );

   assign idle       = (state == ST_IDLE);
   assign hs         = idle && gnt_any;
   assign req0_ready = hs && !gnt;
   assign req1_ready = hs && gnt;

   // ALU drive comes straight from registers so it never follows req inputs
   assign alu_a  = a_p0;
   assign alu_b  = b_p0;
   assign alu_op = op_p0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         owner       <= 1'b0;
         a_p0        <= '0;
         b_p0        <= '0;
         op_p0       <= '0;
         rsp0_valid  <= 1'b0;
         rsp0_result <= '0;
         rsp0_zero   <= 1'b0;
         rsp0_sign   <= 1'b0;
         rsp1_valid  <= 1'b0;
         rsp1_result <= '0;
         rsp1_zero   <= 1'b0;
         rsp1_sign   <= 1'b0;
      end else begin
         case (state)
            // p0: operands latched from the granted requester
            ST_IDLE: begin
               if (hs) begin
                  owner <= gnt;
                  a_p0  <= gnt ? req1_a  : req0_a;
                  b_p0  <= gnt ? req1_b  : req0_b;
                  op_p0 <= gnt ? req1_op : req0_op;
                  state <= ST_EXEC;
               end
            end
            // p1: ALU output captured into the owner's response slot
            ST_EXEC: begin
               if (owner) begin
                  rsp1_result <= alu_out;
                  rsp1_zero   <= alu_zero;
                  rsp1_sign   <= alu_sign;
                  rsp1_valid  <= 1'b1;
               end else begin
                  rsp0_result <= alu_out;
                  rsp0_zero   <= alu_zero;
                  rsp0_sign   <= alu_sign;
                  rsp0_valid  <= 1'b1;
               end
               state <= ST_RESP;
            end
            ST_RESP: begin
               if (owner && rsp1_ready) begin
                  rsp1_valid <= 1'b0;
                  state      <= ST_IDLE;
               end else if (!owner && rsp0_ready) begin
                  rsp0_valid <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters, e.g. the execute stage (port 0) and the address/branch helper (port 1).
- Requests use valid/ready handshakes and are arbitrated round-robin.
- Operands and op are registered before they drive the ALU; the result and flags are registered into a per-requester response slot that is held until that requester accepts it.
- One operation is in flight at a time.

Parameters:
- WIDTH, 32, operand/result width
- OPW, 3, ALU opcode width

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  arbiter accepts requester 0 this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_op  in  OPW  requester 0 ALU opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as port 0, for requester 1
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_result  out  WIDTH  registered ALU result
- rsp0_zero, rsp0_sign  out  1  registered ALU zero/sign flags
- rsp1_valid, rsp1_ready, rsp1_result, rsp1_zero, rsp1_sign  same as port 0, for requester 1
- alu_a, alu_b  out  WIDTH  operands to the shared ALU
- alu_op  out  OPW  opcode to the shared ALU
- alu_out  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_zero, alu_sign  in  1  ALU flags

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (rst=1 at an edge):
  - state=IDLE, last_grant=1 (so port 0 wins the first tie).
  - All operand/op/result regs=0; all rsp*_valid=0.
  - alu_a=alu_b=0, alu_op=000.
  - Reset mid-operation drops the transaction; no response is ever produced for it.
- IDLE:
  - req0_ready/req1_ready asserted combinationally only in IDLE, and only for the granted port.
  - Grant rule: only one valid -> grant it. Both valid -> grant the port != last_grant. Neither valid -> stay IDLE.
  - On handshake: latch a, b, op, owner; last_grant<=owner; go to EXEC.
- EXEC (1 cycle):
  - alu_a/alu_b/alu_op driven from the latched regs.
  - At the edge, alu_out, alu_zero and alu_sign are captured into the owner's response regs; rsp<owner>_valid<=1; go to RESP.
- RESP:
  - rsp<owner>_valid held high with stable data until rsp<owner>_ready=1 at an edge.
  - On that edge: valid<=0 and return to IDLE. A new grant is possible on the next cycle, not the same edge.
  - rsp*_ready while the corresponding valid=0 is ignored.
- ALU drive outside EXEC: alu_* ports hold the last latched operands. They are don't-care for correctness but must be stable (no glitching from req inputs).
- Latency and throughput:
  - Request handshake to rsp_valid = 2 cycles.
  - Minimum 3 cycles per operation with rsp_ready tied high.
- Opcodes, flags and width:
  - Passed through unmodified. Undefined codes (e.g. 011) are issued normally; whatever the ALU returns is reported.
  - Flags are captured exactly as the ALU produces them; no reinterpretation. Result is WIDTH bits, no extension.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1… No starvation.
- Request requirements: requester must hold valid and payload stable until ready. Payload changes while not granted are legal and are sampled only at the handshake.

Decomposition:
- Shared package holds:
  - ALU opcode constants: ADD=000, SLL=001, SUB=010, XOR=100, SRL=101, OR=110, AND=111.
  - FSM state encoding (IDLE/EXEC/RESP, 2 bits).
  - WIDTH/OPW defaults.
- Natural sub-module: rr_arb2, a 2-way round-robin grant with last_grant register and update enable.
- The ALU stays outside this block; it is connected at the next level up.

Test Plan:
- Single op: rst 2 cycles, then req0 ADD a=5 b=7, rsp0_ready=1 -> req0_ready=1 in first cycle; alu_a=5/alu_op=000 in EXEC; rsp0_valid=1 two cycles after handshake with result=12, zero=0.
- Tie and alternation: both valid continuously (req0 SUB 9-9, req1 OR 0xF0|0x0F), ready high -> order 0,1,0,1; rsp0 result=0 zero=1; rsp1 result=0xFF.
- Backpressure: req1 XOR 0xAAAA^0xFFFF with rsp1_ready=0 for 5 cycles -> rsp1_valid and result=0x5555 stable; req0_ready=0 throughout; IDLE the cycle after rsp1_ready=1.
- Reset mid-op: assert rst in EXEC -> next cycle all rsp*_valid=0, state IDLE; no response for the dropped op; first grant after reset goes to port 0.
- Undefined opcode: req0 op=011 with a model ALU returning 0 -> rsp0_result=0, zero=1, issued and completed in normal 2-cycle latency.
- Payload stability: change req1_a while req0 is being served; req1 holds the final value at its grant -> the granted value is the one present at the req1 handshake cycle.
